pcm_response_engine: RTL



---
 rtl/pcm_response_engine_pkg.sv | 40 ++++
 rtl/pcm_response_engine_sig_store.sv | 40 ++++
 rtl/pcm_response_engine.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcm_response_engine_pkg.sv
// Shared types and constants for the PCM response engine: opcodes, FSM states,
// status word bit positions and the saturating fail-counter helper.
package pcm_resp_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'b000,
        OP_ENROLL     = 3'b001,
        OP_VERIFY     = 3'b010,
        OP_LOCK       = 3'b011,
        OP_CLR_STATUS = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DECODE  = 2'b01,
        ST_COMPARE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    localparam int BUSY        = 0;
    localparam int ILLEGAL     = 1;
    localparam int BAD_ID      = 2;
    localparam int POLICY      = 3;
    localparam int MATCH       = 4;
    localparam int FAILCNT_LSB = 8;
    localparam int FAILCNT_MSB = 15;

    localparam logic [7:0] FAIL_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == FAIL_CNT_MAX) begin
            result = FAIL_CNT_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pcm_response_engine_sig_store.sv
// Golden PUF signature register file: one write port, and a read port that
// returns one compare chunk of a selected slot.
module pcm_sig_store
    import pcm_resp_pkg::*;
#(
    parameter int num_ips        = 4,
    parameter int puf_sig_length = 256,
    parameter int cmp_chunk      = 64,
    parameter int slot_w         = 2,
    parameter int cidx_w         = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [slot_w-1:0]         wr_slot,
    input  logic [puf_sig_length-1:0] wr_sig,
    input  logic [slot_w-1:0]         rd_slot,
    input  logic [cidx_w-1:0]         rd_chunk_idx,
    output logic [cmp_chunk-1:0]      rd_chunk
);

    logic [puf_sig_length-1:0] mem_r [num_ips];

    // Signature storage with synchronous clear of every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < num_ips; i++) begin
                mem_r[i] <= {puf_sig_length{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_slot] <= wr_sig;
        end
    end

    // Chunk-indexed combinational read.
    always_comb begin
        rd_chunk = mem_r[rd_slot][int'(rd_chunk_idx) * cmp_chunk +: cmp_chunk];
    end

endmodule

// File: rtl/pcm_response_engine.sv
// PCM-side responder: decodes boot-controller transactions, enrols golden PUF
// signatures and verifies presented ones in constant time, one chunk per cycle.
module pcm_response_engine
    import pcm_resp_pkg::*;
#(
    parameter int pcm_data_width = 32,
    parameter int puf_sig_length = 256,
    parameter int num_ips        = 4,
    parameter int cmp_chunk      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [puf_sig_length-1:0] pcm_sig_in,
    input  logic [pcm_data_width-1:0] pcm_IP_ID_in,
    input  logic [2:0]                pcm_instruction_in,
    input  logic                      pcm_sig_valid,
    output logic [pcm_data_width-1:0] pcm_control_out,
    output logic [pcm_data_width-1:0] pcm_status,
    output logic                      pcm_comp_out,
    output logic                      pcm_S_c,
    output logic                      pcm_A_c
);

    localparam int NUM_CHUNKS = puf_sig_length / cmp_chunk;
    localparam int SLOT_W     = (num_ips > 1) ? $clog2(num_ips) : 1;
    localparam int CIDX_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CIDX_W-1:0]         LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);
    localparam logic [pcm_data_width-1:0] NUM_IPS_W  = pcm_data_width'(num_ips);

    state_e                    state_r, state_s;
    logic [puf_sig_length-1:0] sig_r, sig_s;
    logic [pcm_data_width-1:0] id_r, id_s;
    logic [2:0]                op_r, op_s;
    logic                      acc_r, acc_s;
    logic [CIDX_W-1:0]         cidx_r, cidx_s;
    logic [num_ips-1:0]        enrolled_r, enrolled_s;
    logic [num_ips-1:0]        locked_r, locked_s;
    logic [num_ips-1:0]        ctrl_r, ctrl_s;
    logic                      comp_r, comp_s;
    logic                      illegal_r, illegal_s;
    logic                      bad_id_r, bad_id_s;
    logic                      policy_r, policy_s;
    logic                      match_r, match_s;
    logic [7:0]                fail_cnt_r, fail_cnt_s;
    logic                      busy_r, busy_s;
    logic                      a_c_r, a_c_s;
    logic                      s_c_r, s_c_s;

    logic                      wr_en_s;
    logic [SLOT_W-1:0]         slot_s;
    logic                      id_ok_s;
    logic [cmp_chunk-1:0]      sig_chunk_s;
    logic [cmp_chunk-1:0]      rd_chunk_s;
    logic                      final_mis_s;

    assign slot_s  = id_r[SLOT_W-1:0];
    assign id_ok_s = (id_r < NUM_IPS_W);

    pcm_sig_store #(
        .num_ips        (num_ips),
        .puf_sig_length (puf_sig_length),
        .cmp_chunk      (cmp_chunk),
        .slot_w         (SLOT_W),
        .cidx_w         (CIDX_W)
    ) u_sig_store (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en_s),
        .wr_slot      (slot_s),
        .wr_sig       (sig_r),
        .rd_slot      (slot_s),
        .rd_chunk_idx (cidx_r),
        .rd_chunk     (rd_chunk_s)
    );

    // Presented-signature chunk aligned with the stored chunk being read.
    always_comb begin
        sig_chunk_s = sig_r[int'(cidx_r) * cmp_chunk +: cmp_chunk];
    end

    // Next-state and next-register computation for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        sig_s       = sig_r;
        id_s        = id_r;
        op_s        = op_r;
        acc_s       = acc_r;
        cidx_s      = cidx_r;
        enrolled_s  = enrolled_r;
        locked_s    = locked_r;
        ctrl_s      = ctrl_r;
        comp_s      = comp_r;
        illegal_s   = illegal_r;
        bad_id_s    = bad_id_r;
        policy_s    = policy_r;
        match_s     = match_r;
        fail_cnt_s  = fail_cnt_r;
        a_c_s       = 1'b0;
        s_c_s       = 1'b0;
        wr_en_s     = 1'b0;
        final_mis_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pcm_sig_valid) begin
                    sig_s   = pcm_sig_in;
                    id_s    = pcm_IP_ID_in;
                    op_s    = pcm_instruction_in;
                    a_c_s   = 1'b1;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                state_s = ST_DONE;
                s_c_s   = 1'b1;
                // An illegal opcode is reported as such regardless of its ID.
                if (op_r > OP_CLR_STATUS) begin
                    illegal_s = 1'b1;
                end else if (!id_ok_s && (op_r != OP_NOP) && (op_r != OP_CLR_STATUS)) begin
                    bad_id_s = 1'b1;
                end else begin
                    case (op_r)
                        OP_NOP: begin
                            state_s = ST_DONE;
                        end
                        OP_ENROLL: begin
                            if (locked_r[slot_s]) begin
                                policy_s = 1'b1;
                            end else begin
                                wr_en_s            = 1'b1;
                                enrolled_s[slot_s] = 1'b1;
                                ctrl_s[slot_s]     = 1'b0;
                            end
                        end
                        OP_VERIFY: begin
                            if (!enrolled_r[slot_s]) begin
                                policy_s = 1'b1;
                            end else begin
                                acc_s   = 1'b0;
                                cidx_s  = {CIDX_W{1'b0}};
                                s_c_s   = 1'b0;
                                state_s = ST_COMPARE;
                            end
                        end
                        OP_LOCK: begin
                            if (!enrolled_r[slot_s]) begin
                                policy_s = 1'b1;
                            end else begin
                                locked_s[slot_s] = 1'b1;
                            end
                        end
                        OP_CLR_STATUS: begin
                            illegal_s  = 1'b0;
                            bad_id_s   = 1'b0;
                            policy_s   = 1'b0;
                            match_s    = 1'b0;
                            fail_cnt_s = 8'h00;
                        end
                        default: begin
                            illegal_s = 1'b1;
                        end
                    endcase
                end
            end
            ST_COMPARE: begin
                // Every chunk is visited; the verdict only lands after the last.
                final_mis_s = acc_r | (sig_chunk_s != rd_chunk_s);
                acc_s       = final_mis_s;
                if (cidx_r == LAST_CHUNK) begin
                    state_s        = ST_DONE;
                    s_c_s          = 1'b1;
                    comp_s         = ~final_mis_s;
                    match_s        = ~final_mis_s;
                    ctrl_s[slot_s] = ~final_mis_s;
                    if (final_mis_s) begin
                        fail_cnt_s = sat_inc8(fail_cnt_r);
                    end else begin
                        fail_cnt_s = fail_cnt_r;
                    end
                end else begin
                    cidx_s = cidx_r + CIDX_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sig_r      <= {puf_sig_length{1'b0}};
            id_r       <= {pcm_data_width{1'b0}};
            op_r       <= 3'b000;
            acc_r      <= 1'b0;
            cidx_r     <= {CIDX_W{1'b0}};
            enrolled_r <= {num_ips{1'b0}};
            locked_r   <= {num_ips{1'b0}};
            ctrl_r     <= {num_ips{1'b0}};
            comp_r     <= 1'b0;
            illegal_r  <= 1'b0;
            bad_id_r   <= 1'b0;
            policy_r   <= 1'b0;
            match_r    <= 1'b0;
            fail_cnt_r <= 8'h00;
            busy_r     <= 1'b0;
            a_c_r      <= 1'b0;
            s_c_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            sig_r      <= sig_s;
            id_r       <= id_s;
            op_r       <= op_s;
            acc_r      <= acc_s;
            cidx_r     <= cidx_s;
            enrolled_r <= enrolled_s;
            locked_r   <= locked_s;
            ctrl_r     <= ctrl_s;
            comp_r     <= comp_s;
            illegal_r  <= illegal_s;
            bad_id_r   <= bad_id_s;
            policy_r   <= policy_s;
            match_r    <= match_s;
            fail_cnt_r <= fail_cnt_s;
            busy_r     <= busy_s;
            a_c_r      <= a_c_s;
            s_c_r      <= s_c_s;
        end
    end

    // Output words assembled from registered fields; unused bits stay zero.
    always_comb begin
        pcm_control_out                   = {pcm_data_width{1'b0}};
        pcm_control_out[num_ips-1:0]      = ctrl_r;
        pcm_status                        = {pcm_data_width{1'b0}};
        pcm_status[BUSY]                  = busy_r;
        pcm_status[ILLEGAL]               = illegal_r;
        pcm_status[BAD_ID]                = bad_id_r;
        pcm_status[POLICY]                = policy_r;
        pcm_status[MATCH]                 = match_r;
        pcm_status[FAILCNT_MSB:FAILCNT_LSB] = fail_cnt_r;
    end

    assign pcm_comp_out = comp_r;
    assign pcm_S_c      = s_c_r;
    assign pcm_A_c      = a_c_r;

endmodule
